// File: rtl/fb_arbiter.sv
// Single-port framebuffer arbiter: display reads always win the port, command
// writes queue in a small FIFO and drain into cycles the display leaves free.
module fb_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int WBUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              wr_drop,
  output logic              wr_idle,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int PTR_W = $clog2(WBUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_ent_t;

  wr_ent_t             wbuf_q [WBUF_DEPTH];
  wr_ent_t             head;
  logic [PTR_W-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                push, pop;
  logic                rd_pending_q, rd_pending_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                mem_we_q, mem_we_d;
  logic [DATA_W-1:0]   disp_data_q, disp_data_d;
  logic                disp_valid_q, disp_valid_d;
  logic                wr_ready_q, wr_ready_d;
  logic                wr_drop_q, wr_drop_d;
  logic                wr_idle_q, wr_idle_d;

  assign head = wbuf_q[rptr_q];

  always_comb begin
    // Push is gated by the registered ready, so a full buffer never accepts
    // even when a pop frees a slot on the same edge.
    push         = wr_req & wr_ready_q;
    pop          = !disp_req && (cnt_q != '0);
    cnt_d        = cnt_q + CNT_W'(push) - CNT_W'(pop);
    wptr_d       = push ? wptr_q + PTR_W'(1) : wptr_q;
    rptr_d       = pop  ? rptr_q + PTR_W'(1) : rptr_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_we_d     = 1'b0;
    rd_pending_d = disp_req;
    if (disp_req) begin
      mem_addr_d = disp_addr;
    end else if (pop) begin
      mem_addr_d  = head.addr;
      mem_wdata_d = head.data;
      mem_we_d    = 1'b1;
    end
    disp_valid_d = rd_pending_q;
    disp_data_d  = rd_pending_q ? mem_rdata : disp_data_q;
    wr_drop_d    = wr_req & ~wr_ready_q;
    wr_ready_d   = cnt_d < CNT_W'(WBUF_DEPTH);
    wr_idle_d    = (cnt_d == '0) && !pop;
  end

  always_ff @(posedge clk) begin
    if (push) wbuf_q[wptr_q] <= '{addr: wr_addr, data: wr_data};
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      cnt_q        <= '0;
      rd_pending_q <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      disp_data_q  <= '0;
      disp_valid_q <= 1'b0;
      wr_ready_q   <= 1'b0;
      wr_drop_q    <= 1'b0;
      wr_idle_q    <= 1'b1;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      cnt_q        <= cnt_d;
      rd_pending_q <= rd_pending_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      disp_data_q  <= disp_data_d;
      disp_valid_q <= disp_valid_d;
      wr_ready_q   <= wr_ready_d;
      wr_drop_q    <= wr_drop_d;
      wr_idle_q    <= wr_idle_d;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_we     = mem_we_q;
  assign disp_data  = disp_data_q;
  assign disp_valid = disp_valid_q;
  assign wr_ready   = wr_ready_q;
  assign wr_drop    = wr_drop_q;
  assign wr_idle    = wr_idle_q;
endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter with a behavioural EBR model whose address
// register is the arbiter's mem_addr flop.
module tb_fb_arbiter;
  logic        clk = 1'b0;
  logic        nrst;
  logic        disp_req;
  logic [15:0] disp_addr;
  logic [7:0]  disp_data;
  logic        disp_valid;
  logic        wr_req;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ready, wr_drop, wr_idle;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;

  logic [7:0]  ram [0:65535];
  int          n_chk  = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  fb_arbiter #(.ADDR_W(16), .DATA_W(8), .WBUF_DEPTH(4)) dut (
    .clk(clk), .nrst(nrst),
    .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_data(disp_data), .disp_valid(disp_valid),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .wr_drop(wr_drop), .wr_idle(wr_idle),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  assign mem_rdata = ram[mem_addr];
  always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) ram[a] = 8'(a);
    ram[16'h0010] = 8'hA5;
    ram[16'h0020] = 8'h5A;
    nrst = 1'b0; disp_req = 1'b1; disp_addr = 16'h0010;
    wr_req = 1'b1; wr_addr = 16'h0055; wr_data = 8'h66;

    // reset held with both requests active
    tick(); tick(); tick();
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_disp_data", 32'(disp_data), 32'h0);
    chk("rst_disp_valid", 32'(disp_valid), 32'h0);
    chk("rst_wr_drop", 32'(wr_drop), 32'h0);
    chk("rst_wr_ready", 32'(wr_ready), 32'h0);
    chk("rst_wr_idle", 32'(wr_idle), 32'h1);
    wr_req = 1'b0; disp_req = 1'b0;
    #2 nrst = 1'b1;
    tick();
    chk("rel_wr_ready", 32'(wr_ready), 32'h1);
    chk("rel_wr_idle", 32'(wr_idle), 32'h1);
    chk("rel_mem_we", 32'(mem_we), 32'h0);

    // single read
    disp_req = 1'b1; disp_addr = 16'h0010;
    tick();
    disp_req = 1'b0;
    chk("rd_e0_addr", 32'(mem_addr), 32'h0010);
    chk("rd_e0_we", 32'(mem_we), 32'h0);
    chk("rd_e0_valid", 32'(disp_valid), 32'h0);
    tick();
    chk("rd_e1_valid", 32'(disp_valid), 32'h1);
    chk("rd_e1_data", 32'(disp_data), 32'hA5);
    tick();
    chk("rd_e2_valid", 32'(disp_valid), 32'h0);
    chk("rd_e2_hold", 32'(disp_data), 32'hA5);

    // drain order, one write per cycle
    for (int i = 1; i <= 4; i++) begin
      wr_req = 1'b1; wr_addr = 16'(i); wr_data = 8'(8'h11 * i);
      tick();
      chk("drn_ready", 32'(wr_ready), 32'h1);
      if (i == 1) chk("drn_we_first", 32'(mem_we), 32'h0);
      else begin
        chk("drn_we", 32'(mem_we), 32'h1);
        chk("drn_addr", 32'(mem_addr), 32'(i - 1));
        chk("drn_data", 32'(mem_wdata), 32'(8'(8'h11 * (i - 1))));
      end
    end
    wr_req = 1'b0;
    tick();
    chk("drn_we_last", 32'(mem_we), 32'h1);
    chk("drn_addr_last", 32'(mem_addr), 32'h4);
    chk("drn_data_last", 32'(mem_wdata), 32'h44);
    chk("drn_idle_busy", 32'(wr_idle), 32'h0);
    tick();
    chk("drn_we_off", 32'(mem_we), 32'h0);
    chk("drn_idle", 32'(wr_idle), 32'h1);
    chk("drn_addr_hold", 32'(mem_addr), 32'h4);

    // priority and overflow
    disp_req = 1'b1; disp_addr = 16'h0020;
    for (int i = 1; i <= 5; i++) begin
      wr_req = 1'b1; wr_addr = 16'(16'h0100 + i); wr_data = 8'(8'hB0 + i);
      tick();
      chk("ovf_we", 32'(mem_we), 32'h0);
      chk("ovf_ready", 32'(wr_ready), (i >= 4) ? 32'h0 : 32'h1);
      chk("ovf_drop", 32'(wr_drop), (i == 5) ? 32'h1 : 32'h0);
    end
    wr_req = 1'b0;
    tick();
    chk("ovf_drop_once", 32'(wr_drop), 32'h0);
    chk("ovf_disp_valid", 32'(disp_valid), 32'h1);
    chk("ovf_disp_data", 32'(disp_data), 32'h5A);
    disp_req = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("ovf_drain_we", 32'(mem_we), 32'h1);
      chk("ovf_drain_addr", 32'(mem_addr), 32'(16'h0100 + i));
      chk("ovf_drain_data", 32'(mem_wdata), 32'(8'hB0 + i));
      chk("ovf_drain_ready", 32'(wr_ready), 32'h1);
    end
    tick();
    chk("ovf_no_fifth", 32'(mem_we), 32'h0);
    chk("ovf_addr_hold", 32'(mem_addr), 32'h0104);
    chk("ovf_idle", 32'(wr_idle), 32'h1);

    // tick cadence: display on 1 of every 3 cycles, a push every cycle
    for (int c = 0; c < 9; c++) begin
      disp_req = (c % 3 == 0); disp_addr = 16'(16'h0030 + c);
      wr_req = 1'b1; wr_addr = 16'(16'h0200 + c); wr_data = 8'(c);
      tick();
      if (c % 3 == 0) begin
        chk("cad_rd_we", 32'(mem_we), 32'h0);
        chk("cad_rd_addr", 32'(mem_addr), 32'(16'h0030 + c));
      end else begin
        chk("cad_wr_we", 32'(mem_we), 32'h1);
        chk("cad_wr_addr", 32'(mem_addr), 32'(16'h0200 + (c - c / 3 - 1)));
        chk("cad_wr_data", 32'(mem_wdata), 32'(c - c / 3 - 1));
      end
      chk("cad_valid", 32'(disp_valid), (c % 3 == 1) ? 32'h1 : 32'h0);
      if (c % 3 == 1) chk("cad_data", 32'(disp_data), 32'(16'h0030 + c - 1));
      chk("cad_ready", 32'(wr_ready), 32'h1);
    end
    wr_req = 1'b0; disp_req = 1'b0;
    for (int i = 6; i <= 8; i++) begin
      tick();
      chk("cad_tail_we", 32'(mem_we), 32'h1);
      chk("cad_tail_addr", 32'(mem_addr), 32'(16'h0200 + i));
    end
    tick();
    chk("cad_idle", 32'(wr_idle), 32'h1);

    // async reset while a write is on the port, 3 entries left buffered
    disp_req = 1'b1; disp_addr = 16'h0010;
    for (int i = 0; i < 4; i++) begin
      wr_req = 1'b1; wr_addr = 16'(16'h0300 + i); wr_data = 8'(8'hE0 + i);
      tick();
    end
    wr_req = 1'b0; disp_req = 1'b0;
    tick();
    chk("ara_we_pre", 32'(mem_we), 32'h1);
    chk("ara_addr_pre", 32'(mem_addr), 32'h0300);
    #2 nrst = 1'b0;
    #1;
    chk("ara_we_async", 32'(mem_we), 32'h0);
    chk("ara_valid_async", 32'(disp_valid), 32'h0);
    chk("ara_addr_async", 32'(mem_addr), 32'h0);
    tick();
    #2 nrst = 1'b1;
    tick();
    chk("ara_rel_idle", 32'(wr_idle), 32'h1);
    chk("ara_rel_we", 32'(mem_we), 32'h0);
    tick();
    chk("ara_stale_we", 32'(mem_we), 32'h0);
    chk("ara_stale_ram", 32'(ram[16'h0301]), 32'h01);

    // async reset between a read issue and its data, 3 entries buffered
    disp_req = 1'b1; disp_addr = 16'h0020;
    for (int i = 0; i < 3; i++) begin
      wr_req = 1'b1; wr_addr = 16'(16'h0400 + i); wr_data = 8'(8'hC0 + i);
      tick();
    end
    wr_req = 1'b0; disp_req = 1'b0;
    #2 nrst = 1'b0;
    #1;
    chk("arb_valid_async", 32'(disp_valid), 32'h0);
    chk("arb_data_async", 32'(disp_data), 32'h0);
    tick();
    chk("arb_valid_edge", 32'(disp_valid), 32'h0);
    #2 nrst = 1'b1;
    tick();
    chk("arb_rel_valid", 32'(disp_valid), 32'h0);
    chk("arb_rel_idle", 32'(wr_idle), 32'h1);
    chk("arb_rel_we", 32'(mem_we), 32'h0);
    tick();
    chk("arb_stale_we", 32'(mem_we), 32'h0);
    chk("arb_stale_ram", 32'(ram[16'h0400]), 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fb_arbiter.md
# fb_arbiter

Arbitrates a single-port synchronous framebuffer RAM (one iCE40 EBR-style port) between two requesters: the display pixel fetch path, which has absolute priority, and the command write path, which is decoupled through a small write buffer. It sits between the command processor, the scan-out logic and the RAM. It replaces direct RAM access from either side, so command writes never disturb scan-out timing.

## Interface
- ADDR_W, 16, framebuffer address width
- DATA_W, 8, framebuffer data width
- WBUF_DEPTH, 4, write buffer entries; power of two, ≥2
- clk  in  1  system clock (PLL clock on global buffer)
- nrst  in  1  reset, asynchronous, active-low
- disp_req  in  1  display fetch request, sampled each posedge
- disp_addr  in  ADDR_W  fetch address, valid with disp_req
- disp_data  out  DATA_W  fetched pixel data
- disp_valid  out  1  one-cycle pulse, disp_data valid
- wr_req  in  1  command write request
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- wr_ready  out  1  registered; buffer can accept wr_req this cycle
- wr_drop  out  1  one-cycle pulse, wr_req refused (buffer full)
- wr_idle  out  1  buffer empty and no write in flight
- mem_addr  out  ADDR_W  RAM address, registered
- mem_wdata  out  DATA_W  RAM write data, registered
- mem_we  out  1  RAM write enable, registered
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after mem_addr is presented with mem_we=0

## Operation
- Write buffer: circular FIFO of WBUF_DEPTH {addr,data} entries. Pointers are log2(WBUF_DEPTH) bits and wrap modulo depth. Count is log2(WBUF_DEPTH)+1 bits.
- Push: wr_req=1 and wr_ready=1 at a posedge. If wr_req=1 and wr_ready=0, the entry is discarded and wr_drop pulses for the next cycle.
- Per-posedge port grant, fixed priority:
  - disp_req=1: issue a read. mem_addr<=disp_addr, mem_we<=0, set rd_pending.
  - Else if buffer is non-empty: issue a write. mem_addr<=head addr, mem_wdata<=head data, mem_we<=1, pop.
  - Else: mem_we<=0. mem_addr and mem_wdata hold.
- rd_pending=1 at a posedge: disp_data<=mem_rdata, disp_valid<=1. Otherwise disp_valid<=0 and disp_data holds.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Full with a pop in the same cycle: wr_ready was already 0, so the push is refused and wr_drop pulses. There is no same-cycle bypass.
- wr_ready<=(count_next<WBUF_DEPTH). wr_idle<=(count_next==0) && !(write issued this edge).
- No forwarding: a display read of an address with a buffered write returns the old RAM contents. The command processor uses wr_idle to fence.
- Writes can starve indefinitely while disp_req is held. This is by design: scan-out leaves the blanking interval and the 2 free cycles of each 3-cycle tick for writes.

## Timing
- Reset (nrst low, asynchronous): buffer emptied, rd_pending=0, mem_addr=0, mem_wdata=0, mem_we=0, disp_data=0, disp_valid=0, wr_drop=0, wr_ready=0, wr_idle=1.
- First posedge after reset release: wr_ready=1.
- Display latency: disp_req sampled at edge E0, mem_addr updated at E0, disp_valid=1 with data after E1, i.e. valid during cycle E1..E2.
- Back-to-back disp_req is supported: one disp_valid per cycle, order preserved.
- Write latency: accepted at E0, earliest mem_we at E1 (buffer was empty, no disp_req).
- Throughput: one RAM access per cycle, read or write.
- Reset asserted mid-operation: in-flight read is lost (no disp_valid), buffered writes are lost, and a mem_we being driven drops immediately.

## Test plan
- Reset: hold nrst low with wr_req=1 and disp_req=1.
  - Required: all outputs at their reset values, no wr_drop, no mem_we.
  - Release: wr_ready=1 after the first edge.
- Single read: RAM[0x0010]=0xA5, pulse disp_req with disp_addr=0x0010.
  - Required: mem_addr=0x0010 and mem_we=0 after E0; disp_valid=1 and disp_data=0xA5 for exactly one cycle after E1.
- Drain order: disp_req=0, push (0x0001,0x11), (0x0002,0x22), (0x0003,0x33), (0x0004,0x44) on consecutive cycles.
  - Required: mem_we high on 4 consecutive cycles, one cycle behind each push, addresses and data in push order.
  - Required: wr_idle=1 after the last write.
- Priority and overflow: hold disp_req=1, push 5 writes.
  - Required: mem_we stays 0; wr_ready=0 after the 4th push; 5th push produces a single wr_drop pulse.
  - Release disp_req: the 4 buffered entries drain; the dropped entry never appears.
- Tick cadence: disp_req on 1 cycle of every 3 while pushing one write per cycle.
  - Required: every disp_valid arrives 2 cycles after its request; writes occupy only the non-display cycles; no RAM access conflicts.
- Async reset mid-operation: assert nrst between a read issue and its data, with 3 entries buffered.
  - Required: mem_we drops without waiting for an edge; no disp_valid.
  - After release: wr_idle=1 and no stale writes reach the RAM.
